// File: rtl/hls_deadlock_pkg.sv
// Shared types and frame-geometry helpers for the HLS deadlock report controller.
package hls_deadlock_pkg;

    typedef enum logic [1:0] {
        WATCH,
        COUNT,
        SEND,
        HOLD
    } state_e;

    localparam logic [7:0] RPT_MAGIC = 8'hD1;

    function automatic int calcNw(input int numProc);
        return (numProc + 31) / 32;
    endfunction

    // One header word, NW channel-block words and, optionally, NW idle words.
    function automatic int calcFrameLen(input int nw, input bit idleEn);
        return idleEn ? (1 + 2 * nw) : (1 + nw);
    endfunction

endpackage

// File: rtl/hls_deadlock_persist_cnt.sv
// Persistence counter: confirm fires when the flag has been high for PERSIST consecutive cycles.
module hls_deadlock_persist_cnt #(
    parameter int PERSIST = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic flag,
    output logic confirm
);

    localparam int CW = $clog2(PERSIST);
    localparam logic [CW-1:0] LAST = CW'(PERSIST - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign confirm = enable && flag && (cnt_q == LAST);

    // Any gap, confirmation or disabled phase restarts the count from zero.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!enable || !flag || confirm) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hls_deadlock_report_ctrl.sv
// Debounces HLS deadlock monitor flags and streams a framed snapshot report.
// Define HLS_DEADLOCK_RPT_IDLE_EN to include the per-process idle words in the frame.
module hls_deadlock_report_ctrl
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_MON  = 4,
    parameter int NUM_PROC = 55,
    parameter int PERSIST  = 64,
    parameter int WORD_W   = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_MON-1:0]  mon_block,
    input  logic [NUM_PROC-1:0] proc_idle,
    input  logic [NUM_PROC-1:0] proc_chan_block,
    input  logic                clear,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [WORD_W-1:0]   rpt_data,
    output logic                rpt_last,
    output logic                deadlock,
    output logic [7:0]          event_count
);

    localparam int NW = calcNw(NUM_PROC);
`ifdef HLS_DEADLOCK_RPT_IDLE_EN
    localparam int FRAME_LEN = calcFrameLen(NW, 1'b1);
`else
    localparam int FRAME_LEN = calcFrameLen(NW, 1'b0);
`endif
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_e             state_q;
    logic [7:0]         idx_q;
    logic [NW*32-1:0]   chan_q;
    logic               pend_q;
    logic               deadlock_q;
    logic [7:0]         ecnt_q;
    logic               valid_q;
    logic [WORD_W-1:0]  data_q;
    logic               last_q;

    logic               monAny;
    logic               confirm;
    logic               transfer;
    logic [7:0]         ecntInc;
    logic [7:0]         nextIdx;
    logic [31:0]        header;
    logic [31:0]        nextWord;
    logic [NW*32-1:0]   chanPad;

    assign monAny   = |mon_block;
    assign transfer = valid_q && rpt_ready;
    assign nextIdx  = idx_q + 8'd1;
    assign ecntInc  = (ecnt_q == 8'hFF) ? 8'hFF : ecnt_q + 8'd1;
    assign header   = {RPT_MAGIC, 8'(mon_block), ecntInc, 8'(FRAME_LEN)};

    assign rpt_valid   = valid_q;
    assign rpt_data    = data_q;
    assign rpt_last    = last_q;
    assign deadlock    = deadlock_q;
    assign event_count = ecnt_q;

    hls_deadlock_persist_cnt #(
        .PERSIST(PERSIST)
    ) u_persist (
        .clock  (clock),
        .reset  (reset),
        .enable ((state_q == WATCH) || (state_q == COUNT)),
        .flag   (monAny),
        .confirm(confirm)
    );

    always_comb begin
        chanPad = '0;
        chanPad[NUM_PROC-1:0] = proc_chan_block;
    end

`ifdef HLS_DEADLOCK_RPT_IDLE_EN
    logic [NW*32-1:0] idle_q;
    logic [NW*32-1:0] idlePad;

    always_comb begin
        idlePad = '0;
        idlePad[NUM_PROC-1:0] = proc_idle;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_q <= '0;
        end else if (confirm) begin
            idle_q <= idlePad;
        end
    end
`else
    logic unusedIdle;
    assign unusedIdle = ^proc_idle;
`endif

    // Word after the current one; the header itself is loaded at confirmation.
    always_comb begin
        nextWord = '0;
        for (int w = 0; w < NW; w++) begin
            if (nextIdx == 8'(w + 1)) begin
                nextWord = chan_q[w*32 +: 32];
            end
`ifdef HLS_DEADLOCK_RPT_IDLE_EN
            if (nextIdx == 8'(NW + w + 1)) begin
                nextWord = idle_q[w*32 +: 32];
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= WATCH;
            idx_q      <= '0;
            chan_q     <= '0;
            pend_q     <= 1'b0;
            deadlock_q <= 1'b0;
            ecnt_q     <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            case (state_q)
                WATCH: begin
                    if (monAny) begin
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (confirm) begin
                        state_q    <= SEND;
                        chan_q     <= chanPad;
                        ecnt_q     <= ecntInc;
                        deadlock_q <= 1'b1;
                        valid_q    <= 1'b1;
                        data_q     <= header;
                        last_q     <= 1'b0;
                        idx_q      <= '0;
                        pend_q     <= 1'b0;
                    end else if (!monAny) begin
                        state_q <= WATCH;
                    end
                end
                SEND: begin
                    if (clear) begin
                        pend_q <= 1'b1;
                    end
                    if (transfer) begin
                        if (idx_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= '0;
                            // A clear seen during the frame re-arms right after the last word.
                            if (pend_q || clear) begin
                                state_q    <= WATCH;
                                deadlock_q <= 1'b0;
                                pend_q     <= 1'b0;
                            end else begin
                                state_q <= HOLD;
                            end
                        end else begin
                            idx_q  <= nextIdx;
                            data_q <= nextWord;
                            last_q <= (nextIdx == LAST_IDX);
                        end
                    end
                end
                HOLD: begin
                    if (clear) begin
                        state_q    <= WATCH;
                        deadlock_q <= 1'b0;
                    end
                end
                default: state_q <= WATCH;
            endcase
        end
    end

endmodule

// File: tb/tb_hls_deadlock_report_ctrl.sv
// Self-checking bench for hls_deadlock_report_ctrl (default parameters).
// Honours HLS_DEADLOCK_RPT_IDLE_EN when selecting the expected frame length.
module tb_hls_deadlock_report_ctrl;

`ifdef HLS_DEADLOCK_RPT_IDLE_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 3;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  mon_block;
    logic [54:0] proc_idle;
    logic [54:0] proc_chan_block;
    logic        clear;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [31:0] rpt_data;
    logic        rpt_last;
    logic        deadlock;
    logic [7:0]  event_count;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [3:0]       mon;
        logic [54:0]      chan;
        logic [54:0]      idle;
        logic [4:0][31:0] w;
    } vec_t;

    vec_t vecs [3];

    hls_deadlock_report_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .mon_block      (mon_block),
        .proc_idle      (proc_idle),
        .proc_chan_block(proc_chan_block),
        .clear          (clear),
        .rpt_valid      (rpt_valid),
        .rpt_ready      (rpt_ready),
        .rpt_data       (rpt_data),
        .rpt_last       (rpt_last),
        .deadlock       (deadlock),
        .event_count    (event_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] mon, input logic [54:0] chan,
                                 input logic [54:0] idle, input logic clr, input logic rdy);
        mon_block       = mon;
        proc_chan_block = chan;
        proc_idle       = idle;
        clear           = clr;
        rpt_ready       = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [4:0][31:0] mkWords(input logic [3:0] mon, input logic [7:0] ec,
                                                 input logic [54:0] chan, input logic [54:0] idle);
        logic [4:0][31:0] w;
        w[0] = {8'hD1, 4'h0, mon, ec, 8'(FLEN)};
        w[1] = chan[31:0];
        w[2] = {9'h0, chan[54:32]};
        w[3] = idle[31:0];
        w[4] = {9'h0, idle[54:32]};
        return w;
    endfunction

    // Holds the flags for PERSIST cycles and checks the exact confirmation cycle.
    task automatic confirmDeadlock(input logic [3:0] mon, input logic [54:0] chan,
                                   input logic [54:0] idle);
        applyStimulus(mon, chan, idle, 1'b0, 1'b1);
        repeat (63) tick();
        checkOutput("pre_confirm_deadlock", 32'(deadlock), 32'd0);
        checkOutput("pre_confirm_valid", 32'(rpt_valid), 32'd0);
        tick();
        checkOutput("confirm_deadlock", 32'(deadlock), 32'd1);
        checkOutput("confirm_valid", 32'(rpt_valid), 32'd1);
    endtask

    // Drains one frame; readyMode 1 uses the repeating 1-0-0-1 ready pattern.
    task automatic runFrame(input logic [4:0][31:0] exp, input int readyMode, input int clearAt);
        int got;
        int budget;
        logic rdy;
        logic holding;
        logic [31:0] heldData;
        logic heldLast;
        got = 0;
        budget = 0;
        holding = 1'b0;
        heldData = '0;
        heldLast = 1'b0;
        while (got < FLEN && budget < 200) begin
            rdy = (readyMode == 0) ? 1'b1 : ((budget % 4 == 0) || (budget % 4 == 3));
            checkOutput("valid_in_frame", 32'(rpt_valid), 32'd1);
            if (holding) begin
                checkOutput("stall_data_stable", rpt_data, heldData);
                checkOutput("stall_last_stable", 32'(rpt_last), 32'(heldLast));
            end
            clear = (got == clearAt);
            rpt_ready = rdy;
            if (rpt_valid && rdy) begin
                checkOutput($sformatf("word%0d", got), rpt_data, exp[got]);
                checkOutput($sformatf("last%0d", got), 32'(rpt_last), 32'(got == FLEN - 1));
                got++;
                holding = 1'b0;
            end else begin
                holding = rpt_valid;
                heldData = rpt_data;
                heldLast = rpt_last;
            end
            tick();
            budget++;
        end
        clear = 1'b0;
        rpt_ready = 1'b1;
        checkOutput("frame_word_count", 32'(got), 32'(FLEN));
        checkOutput("frame_end_valid", 32'(rpt_valid), 32'd0);
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("cleared_deadlock", 32'(deadlock), 32'd0);
    endtask

    initial begin : main
        int expEc;
        int sawValid;
        logic [4:0][31:0] w;

        vecs[0].mon  = 4'b0010;
        vecs[0].chan = 55'h1;
        vecs[0].idle = 55'h2;
        vecs[0].w[0] = 32'hD1020100 | FLEN;
        vecs[0].w[1] = 32'h00000001;
        vecs[0].w[2] = 32'h00000000;
        vecs[0].w[3] = 32'h00000002;
        vecs[0].w[4] = 32'h00000000;

        vecs[1].mon  = 4'b1001;
        vecs[1].chan = 55'h7F_FFFF_FFFF_FFFF;
        vecs[1].idle = 55'h0;
        vecs[1].w[0] = 32'hD1090200 | FLEN;
        vecs[1].w[1] = 32'hFFFFFFFF;
        vecs[1].w[2] = 32'h007FFFFF;
        vecs[1].w[3] = 32'h00000000;
        vecs[1].w[4] = 32'h00000000;

        vecs[2].mon  = 4'b1111;
        vecs[2].chan = 55'h40_0000_8000_0001;
        vecs[2].idle = 55'h1_DEAD_BEEF;
        vecs[2].w[0] = 32'hD10F0300 | FLEN;
        vecs[2].w[1] = 32'h80000001;
        vecs[2].w[2] = 32'h00400000;
        vecs[2].w[3] = 32'hDEADBEEF;
        vecs[2].w[4] = 32'h00000001;

        reset = 1'b1;
        applyStimulus(4'h0, '0, '0, 1'b0, 1'b1);
        repeat (3) tick();
        checkOutput("reset_valid", 32'(rpt_valid), 32'd0);
        checkOutput("reset_data", rpt_data, 32'd0);
        checkOutput("reset_last", 32'(rpt_last), 32'd0);
        checkOutput("reset_deadlock", 32'(deadlock), 32'd0);
        checkOutput("reset_ecount", 32'(event_count), 32'd0);
        reset = 1'b0;
        tick();

        expEc = 0;
        for (int i = 0; i < 3; i++) begin
            confirmDeadlock(vecs[i].mon, vecs[i].chan, vecs[i].idle);
            expEc++;
            checkOutput("table_ecount", 32'(event_count), 32'(expEc));
            mon_block = 4'h0;
            runFrame(vecs[i].w, 0, -1);
            checkOutput("hold_deadlock", 32'(deadlock), 32'd1);
            tick();
            checkOutput("hold_no_valid", 32'(rpt_valid), 32'd0);
            pulseClear();
        end

        // A one-cycle gap restarts the persistence count.
        sawValid = 0;
        applyStimulus(4'b0001, 55'h3, 55'h4, 1'b0, 1'b1);
        repeat (63) begin
            tick();
            sawValid |= int'(rpt_valid);
        end
        mon_block = 4'h0;
        tick();
        sawValid |= int'(rpt_valid);
        mon_block = 4'b0001;
        repeat (63) begin
            tick();
            sawValid |= int'(rpt_valid);
        end
        checkOutput("gap_no_valid", 32'(sawValid), 32'd0);
        checkOutput("gap_no_deadlock", 32'(deadlock), 32'd0);
        tick();
        checkOutput("gap_then_confirm", 32'(rpt_valid), 32'd1);
        expEc++;
        mon_block = 4'h0;
        runFrame(mkWords(4'b0001, 8'(expEc), 55'h3, 55'h4), 0, -1);
        pulseClear();

        // Ready stalls.
        confirmDeadlock(4'b0100, 55'h7_0000_0000_0055, 55'h1234_5678);
        expEc++;
        mon_block = 4'h0;
        runFrame(mkWords(4'b0100, 8'(expEc), 55'h7_0000_0000_0055, 55'h1234_5678), 1, -1);
        pulseClear();

        // Clear during the second word re-arms right after the frame.
        confirmDeadlock(4'b0010, 55'h1, 55'h2);
        expEc++;
        mon_block = 4'h0;
        runFrame(mkWords(4'b0010, 8'(expEc), 55'h1, 55'h2), 0, 1);
        checkOutput("pending_clear_deadlock", 32'(deadlock), 32'd0);
        confirmDeadlock(4'b0010, 55'h1, 55'h2);
        expEc++;
        checkOutput("rearm_header", rpt_data, mkWords(4'b0010, 8'(expEc), 55'h1, 55'h2)[0]);
        mon_block = 4'h0;
        runFrame(mkWords(4'b0010, 8'(expEc), 55'h1, 55'h2), 0, -1);
        pulseClear();

        // Persisting flags across HOLD produce a single frame.
        confirmDeadlock(4'b1000, 55'h9, 55'h6);
        expEc++;
        runFrame(mkWords(4'b1000, 8'(expEc), 55'h9, 55'h6), 0, -1);
        sawValid = 0;
        repeat (500) begin
            tick();
            sawValid += int'(rpt_valid);
        end
        checkOutput("hold_extra_valid", 32'(sawValid), 32'd0);
        checkOutput("hold_ecount", 32'(event_count), 32'(expEc));
        checkOutput("hold_deadlock_sticky", 32'(deadlock), 32'd1);
        mon_block = 4'h0;
        pulseClear();

        // Reset during the third word aborts the frame.
        confirmDeadlock(4'b0011, 55'hA, 55'hB);
        w = mkWords(4'b0011, 8'(expEc + 1), 55'hA, 55'hB);
        mon_block = 4'h0;
        tick();
        tick();
        checkOutput("third_word", rpt_data, w[2]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_valid", 32'(rpt_valid), 32'd0);
        checkOutput("abort_deadlock", 32'(deadlock), 32'd0);
        checkOutput("abort_ecount", 32'(event_count), 32'd0);
        tick();
        confirmDeadlock(4'b0100, 55'h5, 55'h3);
        checkOutput("post_reset_header", rpt_data, {8'hD1, 8'h04, 8'h01, 8'(FLEN)});
        mon_block = 4'h0;
        runFrame(mkWords(4'b0100, 8'h01, 55'h5, 55'h3), 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
